// File: rtl/arb2_burst_ctrl.sv
// arb2_burst_ctrl: downstream stage of the two-client arbiter.
// Captures the winning grant while idle, runs that client's burst of len+1
// beats on the shared target with a valid/ready handshake, then pulses the
// owning client's done for one cycle. Every output is decoded from
// registered state, so grant, length and ready inputs never reach an output
// combinationally.
module arb2_burst_ctrl #(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gnt1,
  input  logic          gnt2,
  input  logic [LW-1:0] len1,
  input  logic [LW-1:0] len2,
  input  logic          tgt_rdy,
  output logic          tgt_vld,
  output logic          tgt_sel,
  output logic          tgt_last,
  output logic [LW-1:0] beat_cnt,
  output logic          done1,
  output logic          done2,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q,    state_d;
  logic [LW-1:0] beat_cnt_q, beat_cnt_d;
  logic [LW-1:0] len_q,      len_d;
  logic          sel_q,      sel_d;
  logic          err_q,      err_d;

  logic          at_last;

  // The final beat is reached when the counter equals the latched length;
  // the counter never has to pass 2^LW-1, so it cannot wrap inside a burst.
  assign at_last = (beat_cnt_q == len_q);

  // Next-state and datapath updates: capture in IDLE, count in XFER.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    sel_d      = sel_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (gnt1) begin
          // Client 1 wins a simultaneous grant; the collision is sticky.
          sel_d      = 1'b0;
          len_d      = len1;
          beat_cnt_d = '0;
          state_d    = XFER;
          if (gnt2) err_d = 1'b1;
        end else if (gnt2) begin
          sel_d      = 1'b1;
          len_d      = len2;
          beat_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (tgt_rdy) begin
          if (at_last) state_d    = DONE;
          else         beat_cnt_d = beat_cnt_q + LW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any burst without a done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      len_q      <= '0;
      sel_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
    end
  end

  assign tgt_vld  = (state_q == XFER);
  assign tgt_last = (state_q == XFER) && at_last;
  assign tgt_sel  = sel_q;
  assign beat_cnt = beat_cnt_q;
  assign done1    = (state_q == DONE) && !sel_q;
  assign done2    = (state_q == DONE) &&  sel_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_arb2_burst_ctrl.sv
// tb_arb2_burst_ctrl: directed bench for arb2_burst_ctrl. Each step drives
// inputs, pushes the outputs expected in the following cycle onto a
// scoreboard queue, then pops and compares once the DUT has clocked.
module tb_arb2_burst_ctrl;

  localparam int LW = 4;

  typedef struct {
    string         tag;
    logic          vld;
    logic          last;
    logic          d1;
    logic          d2;
    logic          busy;
    logic          err;
    logic          chk_dp;   // compare sel/cnt only while the target is owned
    logic          sel;
    logic [LW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          gnt1, gnt2, tgt_rdy;
  logic [LW-1:0] len1, len2;
  logic          tgt_vld, tgt_sel, tgt_last, done1, done2, busy, err;
  logic [LW-1:0] beat_cnt;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_err  = 1'b0;

  arb2_burst_ctrl #(.LW(LW)) dut (
    .clk(clk), .rst(rst), .gnt1(gnt1), .gnt2(gnt2), .len1(len1), .len2(len2),
    .tgt_rdy(tgt_rdy), .tgt_vld(tgt_vld), .tgt_sel(tgt_sel),
    .tgt_last(tgt_last), .beat_cnt(beat_cnt), .done1(done1), .done2(done2),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic vld,
                              input logic last, input logic d1, input logic d2,
                              input logic bsy, input logic chk_dp,
                              input logic sel, input int cnt);
    exp_t e;
    e.tag = tag; e.vld = vld; e.last = last; e.d1 = d1; e.d2 = d2;
    e.busy = bsy; e.err = exp_err; e.chk_dp = chk_dp; e.sel = sel;
    e.cnt = LW'(cnt);
    return e;
  endfunction

  // Shorthands: an XFER beat, the DONE cycle, and an IDLE cycle.
  function automatic exp_t x_beat(input string tag, input logic sel,
                                  input int cnt, input logic last);
    return mk(tag, 1'b1, last, 1'b0, 1'b0, 1'b1, 1'b1, sel, cnt);
  endfunction
  function automatic exp_t x_done(input string tag, input logic sel,
                                  input int cnt);
    return mk(tag, 1'b0, 1'b0, !sel, sel, 1'b1, 1'b1, sel, cnt);
  endfunction
  function automatic exp_t x_idle(input string tag);
    return mk(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endfunction

  task automatic compare_pop();
    exp_t e;
    if (q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    check({e.tag, ".vld"},   32'(tgt_vld),  32'(e.vld));
    check({e.tag, ".last"},  32'(tgt_last), 32'(e.last));
    check({e.tag, ".done1"}, 32'(done1),    32'(e.d1));
    check({e.tag, ".done2"}, 32'(done2),    32'(e.d2));
    check({e.tag, ".busy"},  32'(busy),     32'(e.busy));
    check({e.tag, ".err"},   32'(err),      32'(e.err));
    if (e.chk_dp) begin
      check({e.tag, ".sel"}, 32'(tgt_sel),  32'(e.sel));
      check({e.tag, ".cnt"}, 32'(beat_cnt), 32'(e.cnt));
    end
  endtask

  // Push the expectation for the cycle after the next edge, clock, compare.
  task automatic tick(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  // Compare without clocking, for the asynchronous reset response.
  task automatic settle(input exp_t e);
    q.push_back(e);
    #1;
    compare_pop();
  endtask

  initial begin
    rst = 1'b0; gnt1 = 1'b0; gnt2 = 1'b0; tgt_rdy = 1'b0;
    len1 = '0; len2 = '0;

    // Reset held: everything zero, including sel and count.
    repeat (2) @(posedge clk);
    #1;
    settle(mk("rst_hold", 0, 0, 0, 0, 0, 1, 0, 0));
    rst = 1'b1;
    tick(mk("rst_rel", 0, 0, 0, 0, 0, 1, 0, 0));

    // Client 1, three beats, target always ready.
    gnt1 = 1'b1; len1 = 4'd2; tgt_rdy = 1'b1;
    tick(x_beat("c1_b0", 0, 0, 0));
    gnt1 = 1'b0;
    tick(x_beat("c1_b1", 0, 1, 0));
    tick(x_beat("c1_b2", 0, 2, 1));
    tick(x_done("c1_done", 0, 2));
    tick(x_idle("c1_idle"));

    // Client 2, single beat, target stalls for three cycles.
    gnt2 = 1'b1; len2 = 4'd0; tgt_rdy = 1'b0;
    tick(x_beat("c2_stall0", 1, 0, 1));
    gnt2 = 1'b0;
    tick(x_beat("c2_stall1", 1, 0, 1));
    tick(x_beat("c2_stall2", 1, 0, 1));
    tgt_rdy = 1'b1;
    tick(x_done("c2_done", 1, 0));
    tick(x_idle("c2_idle"));

    // Simultaneous grants: client 1 wins, err becomes sticky.
    gnt1 = 1'b1; gnt2 = 1'b1; len1 = 4'd1;
    exp_err = 1'b1;
    tick(x_beat("both_b0", 0, 0, 0));
    gnt1 = 1'b0; gnt2 = 1'b0;
    tick(x_beat("both_b1", 0, 1, 1));
    tick(x_done("both_done", 0, 1));
    tick(x_idle("both_idle0"));
    tick(x_idle("both_idle1"));

    // Grants and lengths changing mid-burst are ignored until IDLE.
    gnt1 = 1'b1; len1 = 4'd3; len2 = 4'd1;
    tick(x_beat("ign_b0", 0, 0, 0));
    gnt1 = 1'b0; gnt2 = 1'b1; len1 = 4'd0;
    tick(x_beat("ign_b1", 0, 1, 0));
    tick(x_beat("ign_b2", 0, 2, 0));
    tick(x_beat("ign_b3", 0, 3, 1));
    tick(x_done("ign_done", 0, 3));
    tick(x_idle("ign_idle"));
    tick(x_beat("ign_c2_b0", 1, 0, 0));
    gnt2 = 1'b0;
    tick(x_beat("ign_c2_b1", 1, 1, 1));
    tick(x_done("ign_c2_done", 1, 1));
    tick(x_idle("ign_c2_idle"));

    // Maximum length burst: 16 beats, no wrap.
    gnt2 = 1'b1; len2 = 4'd15;
    tick(x_beat("max_b0", 1, 0, 0));
    gnt2 = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick(x_beat($sformatf("max_b%0d", i), 1, i, i == 15));
    end
    tick(x_done("max_done", 1, 15));
    tick(x_idle("max_idle"));

    // Reset mid-burst at beat 1: immediate abort, err cleared, no done.
    gnt1 = 1'b1; len1 = 4'd3;
    tick(x_beat("ab_b0", 0, 0, 0));
    gnt1 = 1'b0;
    tick(x_beat("ab_b1", 0, 1, 0));
    rst = 1'b0;
    exp_err = 1'b0;
    settle(mk("ab_async", 0, 0, 0, 0, 0, 1, 0, 0));
    tick(mk("ab_hold", 0, 0, 0, 0, 0, 1, 0, 0));
    rst = 1'b1;
    tick(mk("ab_rel", 0, 0, 0, 0, 0, 1, 0, 0));
    gnt1 = 1'b1; len1 = 4'd0;
    tick(x_beat("ab_new_b0", 0, 0, 1));
    gnt1 = 1'b0;
    tick(x_done("ab_new_done", 0, 0));
    tick(x_idle("ab_new_idle"));

    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
